multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multi-cycle RV32-subset datapath.
//
// States: FETCH(0) -> DECODE(1) -> EXEC(2) -> [MEM(3)] -> [WB(4)] -> FETCH, TRAP(5) on an
// illegal opcode (held until reset). Controls are decoded from the state and the opcode
// latched in DECODE.
//
// Optional feature: define MULTICYCLE_CTRL_INSTRET_EN to build the retired-instruction
// counter; otherwise instret is tied to zero and no counter logic exists.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   opcode     instruction[6:0], sampled only in DECODE
//   mem_ready  memory completion, only looked at while a request is pending
//   mem_req    memory request, held until mem_ready
//   mem_read   read qualifier for mem_req
//   mem_write  write qualifier for mem_req
//   ir_write   IR load strobe
//   pc_write   PC <= PC + 4 strobe
//   alu_op     ALU operation class (00 add, 01 branch compare, 10 funct-decoded)
//   alu_src    ALU B operand select (1 = immediate)
//   mem_to_reg write-back source select (1 = memory data)
//   reg_write  register file write enable
//   branch     branch evaluation enable
//   jump       jump enable
//   state      current FSM state code
//   illegal    sticky illegal-opcode flag
//   instret    retired-instruction count
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  alu_op,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        branch,
    output logic        jump,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] instret
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic [6:0] opc_q, opc_d;
    logic       opc_legal;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            opc_q   <= 7'd0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
        end
    end

    always_comb begin
        opc_legal = (opcode == OpR) || (opcode == OpLoad) || (opcode == OpOpImm) ||
                    (opcode == OpStore) || (opcode == OpBranch) || (opcode == OpJal);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        case (state_q)
            StFetch: begin
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                opc_d   = opcode;
                state_d = opc_legal ? StExec : StTrap;
            end
            StExec: begin
                case (opc_q)
                    OpR, OpOpImm, OpJal: state_d = StWb;
                    OpLoad, OpStore:     state_d = StMem;
                    OpBranch:            state_d = StFetch;
                    default:             state_d = StTrap;
                endcase
            end
            StMem: begin
                if (mem_ready) state_d = (opc_q == OpLoad) ? StWb : StFetch;
            end
            StWb:    state_d = StFetch;
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase
    end

    // Output decode. rst gates everything so a pending request drops before the next edge.
    // ir_write/pc_write must coincide with the accepted fetch read, so they are the only
    // outputs that follow mem_ready within the cycle.
    always_comb begin
        mem_req    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        alu_op     = 2'b00;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    mem_req  = 1'b1;
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                StExec: begin
                    case (opc_q)
                        OpR:             alu_op = 2'b10;
                        OpOpImm: begin
                            alu_op  = 2'b10;
                            alu_src = 1'b1;
                        end
                        OpLoad, OpStore: alu_src = 1'b1;
                        OpBranch: begin
                            alu_op = 2'b01;
                            branch = 1'b1;
                        end
                        OpJal:           jump = 1'b1;
                        default: ;
                    endcase
                end
                StMem: begin
                    alu_src   = 1'b1;
                    mem_req   = 1'b1;
                    mem_read  = (opc_q == OpLoad);
                    mem_write = (opc_q == OpStore);
                end
                StWb: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (opc_q == OpLoad);
                end
                StTrap:  illegal = 1'b1;
                default: ;
            endcase
        end
    end

    assign state = state_q;

`ifdef MULTICYCLE_CTRL_INSTRET_EN
    logic [31:0] instret_q, instret_d;
    logic        retire;

    // Retirement is any return to FETCH from EXEC, MEM or WB.
    always_comb begin
        retire    = ((state_q == StExec) || (state_q == StMem) || (state_q == StWb)) &&
                    (state_d == StFetch);
        instret_d = retire ? instret_q + 32'd1 : instret_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) instret_q <= 32'd0;
        else     instret_q <= instret_d;
    end

    assign instret = instret_q;
`else
    assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks every instruction class, memory stalls,
// the trap state and reset behaviour, comparing the full control word each cycle.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        mem_req, mem_read, mem_write, ir_write, pc_write;
    logic [1:0]  alu_op;
    logic        alu_src, mem_to_reg, reg_write, branch, jump;
    logic [2:0]  state;
    logic        illegal;
    logic [31:0] instret;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_ir = 32'd0;

`ifdef MULTICYCLE_CTRL_INSTRET_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .alu_op     (alu_op),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .branch     (branch),
        .jump       (jump),
        .state      (state),
        .illegal    (illegal),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    logic [15:0] obs;
    assign obs = {state, mem_req, mem_read, mem_write, ir_write, pc_write, alu_op, alu_src,
                  mem_to_reg, reg_write, branch, jump, illegal};

    // Control word: state, req, rd, wr, irw, pcw, aluop, asrc, m2r, rw, br, j, ill.
    function automatic logic [15:0] mk(input logic [2:0] st, input logic rq, input logic rd,
                                       input logic wr, input logic irw, input logic pcw,
                                       input logic [1:0] aop, input logic asrc,
                                       input logic m2r, input logic rw, input logic br,
                                       input logic j, input logic ill);
        return {st, rq, rd, wr, irw, pcw, aop, asrc, m2r, rw, br, j, ill};
    endfunction

    logic [15:0] v_rst, v_fwait, v_fgo, v_dec, v_ex_r, v_ex_i, v_ex_ls, v_ex_b, v_ex_j;
    logic [15:0] v_mem_ld, v_mem_st, v_wb, v_wb_ld, v_trap;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, o, e);
        end
    endtask

    task automatic ctl(input string tag, input logic [15:0] e);
        chk(tag, {16'd0, obs}, {16'd0, e});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic retired;
        if (CntEn) exp_ir = exp_ir + 32'd1;
    endtask

    initial begin
        v_rst    = mk(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        v_fwait  = mk(3'd0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        v_fgo    = mk(3'd0, 1, 1, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0);
        v_dec    = mk(3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        v_ex_r   = mk(3'd2, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0);
        v_ex_i   = mk(3'd2, 0, 0, 0, 0, 0, 2'b10, 1, 0, 0, 0, 0, 0);
        v_ex_ls  = mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        v_ex_b   = mk(3'd2, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 1, 0, 0);
        v_ex_j   = mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        v_mem_ld = mk(3'd3, 1, 1, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        v_mem_st = mk(3'd3, 1, 0, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        v_wb     = mk(3'd4, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0);
        v_wb_ld  = mk(3'd4, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0);
        v_trap   = mk(3'd5, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);

        rst = 1'b1; opcode = 7'd0; mem_ready = 1'b0;
        tick();
        ctl("reset", v_rst);
        chk("reset_instret", instret, 32'd0);
        rst = 1'b0; #1;
        ctl("fetch_wait0", v_fwait);
        tick();
        ctl("fetch_wait1", v_fwait);

        // R-type, opcode change outside DECODE must be ignored.
        mem_ready = 1'b1; opcode = 7'b0110011; #1;
        ctl("r_fetch", v_fgo);
        tick(); ctl("r_decode", v_dec);
        tick(); ctl("r_exec", v_ex_r);
        opcode = 7'b1111111; #1;
        ctl("r_exec_opc_change", v_ex_r);
        tick(); ctl("r_wb", v_wb);
        tick(); retired(); ctl("r_back_fetch", v_fgo);
        chk("r_instret", instret, exp_ir);

        // OP-IMM.
        opcode = 7'b0010011;
        tick(); ctl("i_decode", v_dec);
        tick(); ctl("i_exec", v_ex_i);
        tick(); ctl("i_wb", v_wb);
        tick(); retired(); ctl("i_fetch", v_fgo);
        chk("i_instret", instret, exp_ir);

        // LOAD with three stalled MEM cycles.
        opcode = 7'b0000011;
        tick(); ctl("ld_decode", v_dec);
        tick(); ctl("ld_exec", v_ex_ls);
        mem_ready = 1'b0;
        tick(); ctl("ld_mem0", v_mem_ld);
        tick(); ctl("ld_mem1", v_mem_ld);
        tick(); ctl("ld_mem2", v_mem_ld);
        mem_ready = 1'b1; #1;
        ctl("ld_mem3", v_mem_ld);
        tick(); ctl("ld_wb", v_wb_ld);
        tick(); retired(); ctl("ld_fetch", v_fgo);
        chk("ld_instret", instret, exp_ir);

        // STORE skips WB.
        opcode = 7'b0100011;
        tick(); ctl("st_decode", v_dec);
        tick(); ctl("st_exec", v_ex_ls);
        tick(); ctl("st_mem", v_mem_st);
        tick(); retired(); ctl("st_fetch", v_fgo);
        chk("st_instret", instret, exp_ir);

        // BRANCH returns straight from EXEC.
        opcode = 7'b1100011;
        tick(); ctl("br_decode", v_dec);
        tick(); ctl("br_exec", v_ex_b);
        tick(); retired(); ctl("br_fetch", v_fgo);
        chk("br_instret", instret, exp_ir);

        // JAL.
        opcode = 7'b1101111;
        tick(); ctl("jal_decode", v_dec);
        tick(); ctl("jal_exec", v_ex_j);
        tick(); ctl("jal_wb", v_wb);
        tick(); retired(); ctl("jal_fetch", v_fgo);
        chk("jal_instret", instret, exp_ir);

        // Illegal opcode traps and stays there.
        opcode = 7'b1111111;
        tick(); ctl("ill_decode", v_dec);
        tick(); ctl("ill_trap0", v_trap);
        opcode = 7'b0110011;
        for (int i = 1; i <= 10; i++) begin
            tick();
            ctl($sformatf("ill_trap%0d", i), v_trap);
        end
        chk("ill_instret", instret, exp_ir);
        rst = 1'b1; #1;
        ctl("trap_rst", v_rst);
        exp_ir = 32'd0;
        chk("trap_rst_instret", instret, exp_ir);
        tick();
        rst = 1'b0; mem_ready = 1'b0; #1;
        ctl("trap_rst_fetch", v_fwait);

        // Reset during a pending fetch drops the request before the next edge.
        tick(); ctl("pend_fetch", v_fwait);
        #2 rst = 1'b1; #1;
        ctl("pend_rst_drop", v_rst);
        tick(); ctl("pend_rst_hold", v_rst);
        rst = 1'b0; #1;
        ctl("pend_fresh_req", v_fwait);

`ifdef MULTICYCLE_CTRL_INSTRET_EN
        // Counter wrap across two branches.
        force dut.instret_q = 32'hFFFF_FFFF;
        #1 release dut.instret_q;
        chk("wrap_preset", instret, 32'hFFFF_FFFF);
        mem_ready = 1'b1; opcode = 7'b1100011;
        tick(); tick(); tick();
        ctl("wrap_fetch0", v_fgo);
        chk("wrap_zero", instret, 32'h0000_0000);
        tick(); tick(); tick();
        chk("wrap_one", instret, 32'h0000_0001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
